// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage data memory and its stall controller.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DMEM_DEPTH_DEFAULT  = 256;
    localparam int WAIT_CYCLES_DEFAULT = 2;
    localparam int CNT_W               = 4;

endpackage

// File: rtl/dmem_array.sv
// Word-wide data memory: one synchronous write port, one registered read port.
module dmem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/dmem_stall_ctrl.sv
// Multi-cycle data memory access controller: stalls the pipeline for
// WAIT_CYCLES+1 cycles per load/store and flags illegal accesses.
module dmem_stall_ctrl
    import mips_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT,
    parameter int DMEM_DEPTH  = DMEM_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadMEM,
    input  logic        MemWriteMEM,
    input  logic [31:0] alu_outMEM,
    input  logic [31:0] wdataMEM,
    output logic [31:0] dmem_rdata,
    output logic        en_reg,
    output logic        busy,
    output logic        err
);

    localparam int AW = $clog2(DMEM_DEPTH);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [AW-1:0]    addr_reg;
    logic [31:0]      wdata_reg;
    logic             is_read_reg;
    logic             err_reg;
    logic             rd_valid_reg;

    logic             req;
    logic             accept;
    logic             commit;
    logic             bad_access;
    logic [AW-1:0]    acc_addr;
    logic [31:0]      acc_wdata;
    logic             acc_read;
    logic             mem_we;
    logic             mem_re;
    logic [31:0]      mem_rdata;

    // A request held during reset must not be seen, so en_reg stays 1 and nothing commits.
    assign req        = reset & (MemReadMEM | MemWriteMEM);
    assign bad_access = (alu_outMEM[1:0] != 2'b00) | (MemReadMEM & MemWriteMEM);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        en_reg     = 1'b1;
        accept     = 1'b0;
        commit     = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (req) begin
                    en_reg = 1'b0;
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_next = DONE;
                        commit     = 1'b1;
                    end else begin
                        state_next = BUSY;
                        cnt_next   = WAIT_LOAD;
                    end
                end
            end
            BUSY: begin
                // Leave when the decremented count reaches zero: WAIT_CYCLES busy cycles.
                en_reg   = 1'b0;
                cnt_next = (cnt_reg != '0) ? cnt_reg - 1'b1 : '0;
                if (cnt_reg <= CNT_W'(1)) begin
                    state_next = DONE;
                    commit     = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // With zero wait cycles the access commits on the accepting edge, straight from the inputs.
    always_comb begin
        if (state_reg == IDLE) begin
            acc_addr  = alu_outMEM[AW+1:2];
            acc_wdata = wdataMEM;
            acc_read  = MemReadMEM;
        end else begin
            acc_addr  = addr_reg;
            acc_wdata = wdata_reg;
            acc_read  = is_read_reg;
        end
    end

    assign mem_we = commit & ~acc_read;
    assign mem_re = commit & acc_read;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            is_read_reg  <= 1'b0;
            err_reg      <= 1'b0;
            rd_valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                addr_reg    <= alu_outMEM[AW+1:2];
                wdata_reg   <= wdataMEM;
                is_read_reg <= MemReadMEM;
                if (bad_access) begin
                    err_reg <= 1'b1;
                end
            end
            if (mem_re) begin
                rd_valid_reg <= 1'b1;
            end
        end
    end

    dmem_array #(
        .DEPTH (DMEM_DEPTH),
        .AW    (AW)
    ) u_dmem_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (acc_addr),
        .wdata (acc_wdata),
        .re    (mem_re),
        .raddr (acc_addr),
        .rdata (mem_rdata)
    );

    // The array read register has no reset; mask it until a load has completed since reset.
    assign dmem_rdata = rd_valid_reg ? mem_rdata : 32'h0;
    assign busy       = (state_reg != IDLE);
    assign err        = err_reg;

    generate
        if (AW + 2 < 32) begin : g_upper
            logic unused_addr_bits;
            assign unused_addr_bits = ^alu_outMEM[31:AW+2];
        end
    endgenerate

endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// Bench for dmem_stall_ctrl: two instances (2 and 0 wait cycles) checked against a word-array model.
module tb_dmem_stall_ctrl;

    localparam int DEPTH = 256;
    localparam int W0    = 2;
    localparam int W1    = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        rd_s    [2];
    logic        wr_s    [2];
    logic [31:0] addr_s  [2];
    logic [31:0] wdata_s [2];
    logic [31:0] rdata_o [2];
    logic        en_o    [2];
    logic        busy_o  [2];
    logic        err_o   [2];

    dmem_stall_ctrl #(.WAIT_CYCLES(W0), .DMEM_DEPTH(DEPTH)) dut_w2 (
        .clk(clk), .reset(reset), .MemReadMEM(rd_s[0]), .MemWriteMEM(wr_s[0]),
        .alu_outMEM(addr_s[0]), .wdataMEM(wdata_s[0]), .dmem_rdata(rdata_o[0]),
        .en_reg(en_o[0]), .busy(busy_o[0]), .err(err_o[0])
    );

    dmem_stall_ctrl #(.WAIT_CYCLES(W1), .DMEM_DEPTH(DEPTH)) dut_w0 (
        .clk(clk), .reset(reset), .MemReadMEM(rd_s[1]), .MemWriteMEM(wr_s[1]),
        .alu_outMEM(addr_s[1]), .wdataMEM(wdata_s[1]), .dmem_rdata(rdata_o[1]),
        .en_reg(en_o[1]), .busy(busy_o[1]), .err(err_o[1])
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_mem   [2][DEPTH];
    bit          m_valid [2][DEPTH];
    bit          m_err   [2];
    logic [31:0] m_rdata [2];
    bit          m_rknown[2];

    function automatic int wait_of(input int i);
        return (i == 0) ? W0 : W1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_err[i]    = 1'b0;
            m_rdata[i]  = 32'h0;
            m_rknown[i] = 1'b1;
        end
    endtask

    task automatic check_quiet(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_w%0d_en", tag, wait_of(i)), 32'(en_o[i]), 32'd1);
            check($sformatf("%s_w%0d_busy", tag, wait_of(i)), 32'(busy_o[i]), 32'd0);
            check($sformatf("%s_w%0d_err", tag, wait_of(i)), 32'(err_o[i]), 32'(m_err[i]));
            if (m_rknown[i])
                check($sformatf("%s_w%0d_rdata", tag, wait_of(i)), rdata_o[i], m_rdata[i]);
        end
    endtask

    // Idle cycles: called and returning at 1 time unit after a rising edge.
    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            check_quiet("idle");
            @(posedge clk); #1;
        end
    endtask

    // One access on instance i; the caller's IDLE cycle starts now.
    task automatic do_access(input int i, input bit r, input bit w,
                             input logic [31:0] a, input logic [31:0] d);
        int          idx;
        int          stalls;
        bit          done;
        logic [31:0] exp_rd;
        bit          exp_known;

        idx = int'((a >> 2) % DEPTH);
        rd_s[i] = r; wr_s[i] = w; addr_s[i] = a; wdata_s[i] = d;

        if ((a % 4) != 0 || (r && w)) m_err[i] = 1'b1;
        if (r) begin
            exp_known   = m_valid[i][idx];
            exp_rd      = m_mem[i][idx];
            m_rdata[i]  = exp_rd;
            m_rknown[i] = exp_known;
        end else begin
            exp_known        = m_rknown[i];
            exp_rd           = m_rdata[i];
            m_mem[i][idx]    = d;
            m_valid[i][idx]  = 1'b1;
        end

        stalls = 0;
        done   = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                if (c == 1) begin
                    addr_s[i]  = $urandom;
                    wdata_s[i] = $urandom;
                end
            end
            @(negedge clk);
            if (en_o[i] === 1'b0) stalls++;
            else begin
                done = 1'b1;
                break;
            end
        end

        check($sformatf("w%0d_access_done a=%h", wait_of(i), a), 32'(done), 32'd1);
        check($sformatf("w%0d_stalls a=%h", wait_of(i), a), stalls, wait_of(i) + 1);
        check($sformatf("w%0d_done_busy a=%h", wait_of(i), a), 32'(busy_o[i]), 32'd1);
        check($sformatf("w%0d_done_err a=%h", wait_of(i), a), 32'(err_o[i]), 32'(m_err[i]));
        if (exp_known)
            check($sformatf("w%0d_done_rdata a=%h r=%0d", wait_of(i), a, r), rdata_o[i], exp_rd);

        @(posedge clk); #1;
        rd_s[i] = 1'b0; wr_s[i] = 1'b0; addr_s[i] = 32'h0; wdata_s[i] = 32'h0;
    endtask

    initial begin
        int          idx;
        logic [31:0] a;

        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rd_s[i] = 1'b0; wr_s[i] = 1'b0; addr_s[i] = 32'h0; wdata_s[i] = 32'h0;
            for (int k = 0; k < DEPTH; k++) m_valid[i][k] = 1'b0;
        end
        model_reset();

        // Held in reset: quiet outputs, en_reg high
        repeat (3) begin
            @(negedge clk);
            check_quiet("in_reset");
        end
        reset = 1'b1;
        @(posedge clk); #1;
        idle(10);

        // Store then load, 2 wait cycles
        do_access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        do_access(0, 1'b1, 1'b0, 32'h10, 32'h0);
        check("w2_load_deadbeef", m_rdata[0], 32'hDEADBEEF);
        idle(2);

        // Back-to-back loads, zero wait cycles
        do_access(1, 1'b0, 1'b1, 32'h0, 32'hA5A5_0000);
        do_access(1, 1'b0, 1'b1, 32'h4, 32'h0000_5A5A);
        idle(1);
        do_access(1, 1'b1, 1'b0, 32'h0, 32'h0);
        do_access(1, 1'b1, 1'b0, 32'h4, 32'h0);
        idle(2);

        // Random aligned traffic with random upper address bits (wrap)
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 30; k++) begin
                idx = $urandom_range(0, 31);
                a   = ($urandom & 32'hFFFF_FC00) | (32'(idx) << 2);
                if (!m_valid[i][idx] || $urandom_range(0, 1) == 0)
                    do_access(i, 1'b0, 1'b1, a, $urandom);
                else
                    do_access(i, 1'b1, 1'b0, a, 32'h0);
                if ($urandom_range(0, 3) == 0) idle(1);
            end
        end
        idle(1);

        // Misaligned load wraps to word 0 and sets the sticky error
        do_access(0, 1'b0, 1'b1, 32'h0, 32'h1357_9BDF);
        do_access(0, 1'b1, 1'b0, 32'h402, 32'h0);
        idle(5);

        // Simultaneous read and write: read wins, word 2 untouched
        do_access(1, 1'b0, 1'b1, 32'h8, 32'hCAFE_F00D);
        do_access(1, 1'b1, 1'b1, 32'h8, 32'h1234_5678);
        do_access(1, 1'b1, 1'b0, 32'h8, 32'h0);
        check("w0_word2_unchanged", m_rdata[1], 32'hCAFE_F00D);
        idle(3);

        // Reset during a store aborts it
        do_access(0, 1'b0, 1'b1, 32'h20, 32'h0BAD_0001);
        rd_s[0] = 1'b0; wr_s[0] = 1'b1; addr_s[0] = 32'h20; wdata_s[0] = 32'h7777_7777;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("w2_busy_before_abort", 32'(busy_o[0]), 32'd1);
        #2 reset = 1'b0;
        model_reset();
        #1;
        check_quiet("abort_reset");
        wr_s[0] = 1'b0; addr_s[0] = 32'h0; wdata_s[0] = 32'h0;
        @(posedge clk);
        @(negedge clk);
        check_quiet("abort_hold");
        reset = 1'b1;
        @(posedge clk); #1;
        idle(2);
        do_access(0, 1'b1, 1'b0, 32'h20, 32'h0);
        check("w2_aborted_store_old", m_rdata[0], 32'h0BAD_0001);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_stall_ctrl.md
DMEM_STALL_CTRL -- requirements
Module: dmem_stall_ctrl

Interface
REQ-001 Parameter: WAIT_CYCLES, default 2, number of extra memory wait cycles per access (legal range 0..15).
REQ-002 Parameter: DMEM_DEPTH, default 256, data memory depth in 32-bit words.
REQ-003 Port: clk  input  1  single clock; all state updates on posedge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: MemReadMEM  input  1  MEM-stage load request.
REQ-006 Port: MemWriteMEM  input  1  MEM-stage store request.
REQ-007 Port: alu_outMEM  input  32  byte address of the access.
REQ-008 Port: wdataMEM  input  32  store data.
REQ-009 Port: dmem_rdata  output  32  registered load data, feeding the MEM/WB register.
REQ-010 Port: en_reg  output  1  pipeline-wide register enable; 0 = stall all pipeline registers.
REQ-011 Port: busy  output  1  high while an access is in progress (state BUSY or DONE).
REQ-012 Port: err  output  1  sticky error flag: misaligned address, or simultaneous read and write.

Function
REQ-013 FSM states SHALL be IDLE, BUSY, DONE.
REQ-014 IDLE: if MemReadMEM or MemWriteMEM is high, go to BUSY with counter = WAIT_CYCLES; if WAIT_CYCLES = 0, go directly to DONE instead.
REQ-015 BUSY: decrement counter each cycle; go to DONE on the cycle the counter equals 0.
REQ-016 DONE: unconditionally return to IDLE on the next edge.
REQ-017 en_reg SHALL be combinational: 0 when (IDLE and a request is present) or BUSY; 1 otherwise, including the DONE cycle.
REQ-018 A request causes exactly WAIT_CYCLES+1 stall cycles (en_reg=0); the pipeline advances at the edge that leaves DONE.
REQ-019 In DONE the request inputs SHALL be ignored, so the same instruction is never re-triggered; a new request is first seen in the IDLE cycle that follows.
REQ-020 Address decode: word index = alu_outMEM[log2(DMEM_DEPTH)+1:2]; upper bits are ignored, so addresses wrap modulo DMEM_DEPTH*4.
REQ-021 Read: dmem_rdata is loaded from memory at the edge entering DONE and holds its value until the next read completes.
REQ-022 Write: memory is written at the edge entering DONE; dmem_rdata is unchanged by a write.
REQ-023 Address and data SHALL be sampled at the edge leaving IDLE and held internally for the whole access; input changes during BUSY have no effect.
REQ-024 alu_outMEM[1:0] != 0 on an accepted request SHALL set err; the access still proceeds, using the word index.
REQ-025 MemReadMEM and MemWriteMEM both high SHALL set err; the access is performed as a read and the write is dropped.
REQ-026 err SHALL clear only on reset.

Reset
REQ-027 While reset is low: state = IDLE, counter = 0, dmem_rdata = 0, err = 0, busy = 0.
REQ-028 en_reg SHALL equal 1 during reset, since no request is considered while in reset.
REQ-029 Reset asserted mid-access SHALL abort the access: no memory write occurs after reset assertion.
REQ-030 Memory array contents are not reset.

Structure
REQ-031 A shared package mips_mem_pkg SHALL hold the FSM state encoding, the DMEM_DEPTH default, and the WAIT_CYCLES default.
REQ-032 One sub-module, dmem_array, SHALL hold the memory: one synchronous write port and one synchronous read port, no reset.
REQ-033 The FSM, counter, error logic, and en_reg decode SHALL live in dmem_stall_ctrl.

Verification
REQ-034 Reset release, no requests for 10 cycles -> en_reg=1, busy=0, dmem_rdata=0, err=0 throughout.
REQ-035 WAIT_CYCLES=2, store 0xDEADBEEF to 0x10, then load from 0x10 -> each access gives exactly 3 stall cycles; dmem_rdata=0xDEADBEEF during the load's DONE cycle.
REQ-036 WAIT_CYCLES=0, back-to-back loads from 0x0 and 0x4 -> 1 stall cycle each, one IDLE cycle between them, correct data for each load.
REQ-037 Load from 0x402 with DMEM_DEPTH=256 -> err=1, data returned from word index 0; err stays 1 until reset.
REQ-038 Store to 0x20, reset pulsed low during BUSY, then load from 0x20 -> store not committed (old value returned); state is IDLE and en_reg=1 immediately after reset.
REQ-039 MemReadMEM=MemWriteMEM=1 at 0x8 with data 0x12345678 -> err=1, read performed, memory word 2 unchanged.
